// File: rtl/sdm_bank.sv
// sdm_bank: bank of NCH first- or second-order delta-sigma modulators sharing a
// single divided modulator clock SDCLK derived from EXTCLK.
module sdm_bank #(
  parameter int NCH    = 2,
  parameter int DW     = 16,
  parameter int CLKDIV = 4,
  parameter int ORDER  = 2
) (
  input  logic              EXTCLK,
  input  logic              EXTRSTn,
  input  logic              EN,
  input  logic [NCH-1:0]    LOAD,
  input  logic [NCH*DW-1:0] DIN,
  input  logic              CLR,
  output logic              SDCLK,
  output logic [NCH-1:0]    SDOUT,
  output logic [NCH-1:0]    OVF
);
  localparam int CW = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;
  localparam int IW = DW + 4;
  localparam int EW = DW + 6;
  localparam logic [CW-1:0]        CNT_LAST = CW'(CLKDIV - 1);
  localparam logic signed [EW-1:0] FS       = EW'((1 << (DW - 1)) - 1);
  localparam logic signed [EW-1:0] IMAX     = EW'((1 << (IW - 1)) - 1);
  localparam logic signed [EW-1:0] IMIN     = ~IMAX;

  if (ORDER != 1 && ORDER != 2) begin : g_bad_order
    $error("sdm_bank: ORDER must be 1 or 2");
  end

  logic [CW-1:0] r_cnt;
  logic          r_sdclk;
  logic          r_upd;
  logic          w_wrap;
  logic          w_upd;

  assign w_wrap = (r_cnt == CNT_LAST);
  // UPD is the cycle after the SDCLK rise, so SDOUT trails SDCLK by one EXTCLK.
  assign w_upd  = r_upd & EN;
  assign SDCLK  = r_sdclk;

  always_ff @(posedge EXTCLK or negedge EXTRSTn) begin
    if (!EXTRSTn) begin
      r_cnt   <= '0;
      r_sdclk <= 1'b0;
      r_upd   <= 1'b0;
    end else if (!EN) begin
      r_cnt   <= '0;
      r_sdclk <= 1'b0;
      r_upd   <= 1'b0;
    end else begin
      r_upd <= w_wrap & ~r_sdclk;
      if (w_wrap) begin
        r_cnt   <= '0;
        r_sdclk <= ~r_sdclk;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    logic signed [DW-1:0] r_shadow;
    logic signed [DW-1:0] r_active;
    logic signed [IW-1:0] r_int1;
    logic signed [IW-1:0] r_int2;
    logic                 r_sd;
    logic                 r_ovf;
    logic signed [DW-1:0] w_act;
    logic signed [EW-1:0] w_fb;
    logic signed [EW-1:0] w_sum1;
    logic signed [EW-1:0] w_sum2;
    logic signed [IW-1:0] w_int1;
    logic signed [IW-1:0] w_int2;
    logic                 w_sat;
    logic                 w_bit;

    always_comb begin
      w_act  = r_active;
      w_fb   = r_sd ? FS : -FS;
      w_sum1 = '0;
      w_sum2 = '0;
      w_int1 = r_int1;
      w_int2 = '0;
      w_sat  = 1'b0;
      w_bit  = r_sd;
      // A LOAD coincident with UPD feeds the fresh sample straight into this update.
      if (w_upd) w_act = LOAD[g] ? DIN[g*DW +: DW] : r_shadow;
      w_sum1 = EW'(r_int1) + EW'(w_act) - w_fb;
      if (w_sum1 > IMAX) begin
        w_int1 = IMAX[IW-1:0];
        w_sat  = 1'b1;
      end else if (w_sum1 < IMIN) begin
        w_int1 = IMIN[IW-1:0];
        w_sat  = 1'b1;
      end else begin
        w_int1 = w_sum1[IW-1:0];
      end
      if (ORDER == 2) begin
        w_sum2 = EW'(r_int2) + EW'(w_int1) - w_fb;
        if (w_sum2 > IMAX) begin
          w_int2 = IMAX[IW-1:0];
          w_sat  = 1'b1;
        end else if (w_sum2 < IMIN) begin
          w_int2 = IMIN[IW-1:0];
          w_sat  = 1'b1;
        end else begin
          w_int2 = w_sum2[IW-1:0];
        end
        w_bit = ~w_int2[IW-1];
      end else begin
        w_bit = ~w_int1[IW-1];
      end
    end

    always_ff @(posedge EXTCLK or negedge EXTRSTn) begin
      if (!EXTRSTn) begin
        r_shadow <= '0;
        r_active <= '0;
        r_int1   <= '0;
        r_int2   <= '0;
        r_sd     <= 1'b0;
        r_ovf    <= 1'b0;
      end else begin
        if (LOAD[g]) r_shadow <= DIN[g*DW +: DW];
        r_active <= w_act;
        if (w_upd) begin
          r_int1 <= w_int1;
          r_int2 <= w_int2;
          r_sd   <= w_bit;
        end
        // Set wins over a simultaneous clear.
        r_ovf <= (w_upd & w_sat) | (r_ovf & ~CLR);
      end
    end

    assign SDOUT[g] = r_sd;
    assign OVF[g]   = r_ovf;
  end

endmodule

// File: tb/tb_sdm_bank.sv
// Scoreboard bench for sdm_bank: ORDER=2 and ORDER=1 instances driven in parallel
// with directed vectors; a monitor compares SDOUT at every modulator update.
module tb_sdm_bank;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [1:0]  load;
  logic [31:0] din;
  logic        clr;
  logic        sdclk2, sdclk1;
  logic [1:0]  sdout2, sdout1, ovf2, ovf1;

  int checks = 0;
  int errors = 0;

  logic [3:0] q[$];
  logic [3:0] cur_exp;
  logic [3:0] last_exp;
  bit         pend;
  bit         have_last;

  always #5 clk = ~clk;

  sdm_bank #(.NCH(2), .DW(16), .CLKDIV(4), .ORDER(2)) dut2 (
    .EXTCLK(clk), .EXTRSTn(rst_n), .EN(en), .LOAD(load), .DIN(din), .CLR(clr),
    .SDCLK(sdclk2), .SDOUT(sdout2), .OVF(ovf2));

  sdm_bank #(.NCH(2), .DW(16), .CLKDIV(4), .ORDER(1)) dut1 (
    .EXTCLK(clk), .EXTRSTn(rst_n), .EN(en), .LOAD(load), .DIN(din), .CLR(clr),
    .SDCLK(sdclk1), .SDOUT(sdout1), .OVF(ovf1));

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_range(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic fail_timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out waiting, required event never seen", name);
  endtask

  // Monitor: on each SDCLK rise pop an expectation, check SDOUT held, then check it one cycle later.
  initial begin
    bit prev_sd;
    prev_sd = 1'b0;
    pend = 1'b0;
    have_last = 1'b0;
    last_exp = '0;
    cur_exp = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pend = 1'b0;
        have_last = 1'b1;
        last_exp = '0;
        prev_sd = 1'b0;
      end else begin
        if (pend) begin
          chk("upd_sdout_o2", sdout2, cur_exp[3:2]);
          chk("upd_sdout_o1", sdout1, cur_exp[1:0]);
          last_exp = cur_exp;
          have_last = 1'b1;
          pend = 1'b0;
        end
        if (!prev_sd && sdclk2) begin
          if (q.size() > 0) begin
            if (have_last) begin
              chk("rise_hold_o2", sdout2, last_exp[3:2]);
              chk("rise_hold_o1", sdout1, last_exp[1:0]);
            end
            cur_exp = q.pop_front();
            pend = 1'b1;
          end else begin
            have_last = 1'b0;
          end
        end
        prev_sd = sdclk2;
      end
    end
  end

  task automatic wait_rise(output bit ok);
    bit p;
    ok = 1'b0;
    p = sdclk2;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (!p && sdclk2) begin
        ok = 1'b1;
        break;
      end
      p = sdclk2;
    end
    if (!ok) fail_timeout("sdclk_rise");
  endtask

  task automatic count_to_rise(output int n);
    n = 0;
    while (n < 64) begin
      @(negedge clk);
      n++;
      if (sdclk2) break;
    end
  endtask

  task automatic drain(input string name);
    int i;
    i = 0;
    while ((q.size() != 0 || pend) && i < 400) begin
      @(negedge clk);
      i++;
    end
    if (q.size() != 0 || pend) fail_timeout(name);
  endtask

  task automatic do_reset();
    en = 1'b0;
    load = '0;
    din = '0;
    clr = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic load_both(input logic [15:0] d1, input logic [15:0] d0);
    @(negedge clk);
    din = {d1, d0};
    load = 2'b11;
    @(negedge clk);
    load = '0;
    din = '0;
  endtask

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, h, lo, c0, c12, c11, wait_n, rises;
    bit ok;
    rst_n = 1'b0; en = 1'b0; load = '0; din = '0; clr = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_sdclk", {sdclk2, sdclk1}, 0);
    chk("rst_sdout", {sdout2, sdout1}, 0);
    chk("rst_ovf", {ovf2, ovf1}, 0);

    // Directed trajectories: ch0 = 0, ch1 = +16384; entries are {order2 sdout, order1 sdout}.
    @(negedge clk) rst_n = 1'b1;
    load_both(16'h4000, 16'h0000);
    q.push_back({2'b11, 2'b11}); q.push_back({2'b11, 2'b11});
    q.push_back({2'b10, 2'b10}); q.push_back({2'b11, 2'b11});
    q.push_back({2'b00, 2'b00}); q.push_back({2'b10, 2'b11});
    q.push_back({2'b11, 2'b10}); q.push_back({2'b11, 2'b11});
    en = 1'b1;
    count_to_rise(n);
    chk("en_to_first_rise", n, 4);
    h = 0;
    while (sdclk2 && h < 64) begin @(negedge clk); h++; end
    chk("sdclk_high_cycles", h, 4);
    lo = 0;
    while (!sdclk2 && lo < 64) begin @(negedge clk); lo++; end
    chk("sdclk_low_cycles", lo, 4);
    chk("sdclk_o1_matches", sdclk1, 1);
    drain("drain_phase_a");

    // Ones density over long windows.
    c0 = 0; c12 = 0; c11 = 0;
    for (int k = 0; k < 16 + 4096; k++) begin
      wait_rise(ok);
      if (!ok) break;
      @(negedge clk);
      if (k >= 16) begin
        if (k < 16 + 1024) c0 += int'(sdout2[0]);
        c12 += int'(sdout2[1]);
        c11 += int'(sdout1[1]);
      end
    end
    chk_range("density_mid_o2", c0, 508, 516);
    chk_range("density_16384_o2", c12, 3056, 3088);
    chk_range("density_16384_o1", c11, 3056, 3088);
    chk("density_ovf_o2", ovf2, 0);
    chk("density_ovf_o1", ovf1, 0);

    // LOAD[1] = -32767 coincident with the first UPD; ch0 must keep its shadow 0.
    do_reset();
    load_both(16'h0000, 16'h0000);
    q.push_back({2'b11, 2'b11}); q.push_back({2'b01, 2'b01});
    q.push_back({2'b00, 2'b00}); q.push_back({2'b01, 2'b01});
    en = 1'b1;
    wait_rise(ok);
    din = {16'h8001, 16'h3039};
    load = 2'b10;
    @(negedge clk);
    load = '0;
    din = '0;
    drain("drain_phase_b");
    wait_n = 0;
    while (!ovf2[1] && wait_n < 2000) begin @(negedge clk); wait_n++; end
    if (!ovf2[1]) fail_timeout("ovf1_rise");
    chk("ovf_ch0_isolated", ovf2[0], 0);
    wait_rise(ok);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    chk("clr_vs_set", ovf2[1], 1);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    chk("clr_clears_ch1", ovf2[1], 0);
    chk("ovf_o1_none", ovf1, 0);

    // Channel 0 at -32768 saturates; channel 1 stays clean.
    do_reset();
    load_both(16'h0000, 16'h8000);
    en = 1'b1;
    wait_n = 0;
    while (!ovf2[0] && wait_n < 2000) begin @(negedge clk); wait_n++; end
    if (!ovf2[0]) fail_timeout("ovf0_rise");
    chk("ovf_ch1_quiet", ovf2[1], 0);
    for (int k = 0; k < 4; k++) wait_rise(ok);
    @(negedge clk);
    chk("ovf0_sticky", ovf2, 2'b01);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    chk("clr_clears_ch0", ovf2[0], 0);
    wait_rise(ok);
    @(negedge clk);
    chk("ovf0_resets", ovf2, 2'b01);

    // EN dropped mid-period after two updates at mid-scale, then reset while SDCLK high.
    do_reset();
    load_both(16'h0000, 16'h0000);
    en = 1'b1;
    wait_rise(ok);
    wait_rise(ok);
    @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    chk("en_off_sdclk", sdclk2, 0);
    chk("en_off_sdout_o2", sdout2, 2'b11);
    chk("en_off_sdout_o1", sdout1, 2'b11);
    rises = 0;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      if (sdclk2) rises++;
    end
    chk("en_off_no_sdclk", rises, 0);
    chk("en_off_hold_o2", sdout2, 2'b11);
    en = 1'b1;
    wait_rise(ok);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_sdclk", {sdclk2, sdclk1}, 0);
    chk("rst_mid_sdout", {sdout2, sdout1}, 0);
    chk("rst_mid_ovf", {ovf2, ovf1}, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    count_to_rise(n);
    chk("rst_release_to_rise", n, 4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
